// File: rtl/status_flag_unit.sv
// NZCV status register with one-deep pending update, bypass view and
// a shadow copy for save/restore around exceptions.
module status_flag_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        s_bit,
    input  logic [1:0]  flag_class,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        flush,
    input  logic        save_req,
    input  logic        restore_req,
    output logic [3:0]  status,
    output logic [3:0]  status_fwd,
    output logic        flags_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] status_q, status_nxt;
    logic [3:0] shadow_q, shadow_nxt;
    logic [3:0] pend_q, pend_nxt;
    logic [3:0] new_flags;
    logic       accept;
    logic       arith;

    assign status     = status_q;
    assign flags_busy = (state == PEND);
    assign status_fwd = (state == PEND) ? pend_q : status_q;

    assign accept = ex_valid & s_bit & (flag_class != 2'b11) & ~flush;
    assign arith  = (flag_class == 2'b01) | (flag_class == 2'b10);

    // Logic ops inherit C/V from the bypass view so a pending add is seen
    always_comb begin
        new_flags    = 4'b0000;
        new_flags[3] = alu_result[31];
        new_flags[2] = (alu_result == 32'h0);
        new_flags[1] = arith ? alu_c : status_fwd[1];
        new_flags[0] = arith ? alu_v : status_fwd[0];
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        shadow_nxt = shadow_q;
        pend_nxt   = pend_q;
        if (restore_req) begin
            status_nxt = shadow_q;
            state_nxt  = IDLE;
        end else if (flush) begin
            state_nxt = IDLE;
        end else begin
            if (state == PEND)
                status_nxt = pend_q;
            if (accept) begin
                pend_nxt  = new_flags;
                state_nxt = PEND;
            end else begin
                state_nxt = IDLE;
            end
        end
        if (save_req)
            shadow_nxt = status_fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            status_q <= 4'b0000;
            shadow_q <= 4'b0000;
            pend_q   <= 4'b0000;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
            shadow_q <= shadow_nxt;
            pend_q   <= pend_nxt;
        end
    end

endmodule

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- ex_valid  in  1  EX-stage instruction valid
- s_bit  in  1  instruction sets flags
- flag_class  in  2  00 logic, 01 add, 10 sub, 11 no-flag
- alu_result  in  32  ALU result
- alu_c  in  1  ALU carry (sub: 1 = no borrow)
- alu_v  in  1  ALU signed overflow
- flush  in  1  kill pending update
- save_req  in  1  copy status to shadow
- restore_req  in  1  copy shadow to status
- status  out  4  committed {N,Z,C,V}, bit3 = N
- status_fwd  out  4  bypass view for condition evaluation
- flags_busy  out  1  flag update pending

Function
REQ-003 Flag generation SHALL be combinational from EX inputs: N = alu_result[31], Z = (alu_result == 32'h0).
REQ-004 For flag_class 01/10, C = alu_c and V = alu_v; for 00, C and V SHALL keep their current status_fwd values.
REQ-005 An update SHALL be accepted when ex_valid & s_bit & flag_class != 11 & !flush.
- The accepted update is captured into a pending register (pend_valid, pend_flags) at that rising edge.
REQ-006 A pending update SHALL commit to status at the next rising edge: latency = 1 cycle from capture to status, 2 edges from EX presentation.
- If flush is high in the commit cycle, the pending update SHALL be discarded and status SHALL be unchanged.
REQ-007 Back-to-back accepted updates SHALL both commit in order; a new capture SHALL overwrite pend_flags in the same edge the previous one commits.
REQ-008 The pending state machine SHALL have two states, IDLE and PEND.
- IDLE -> PEND on accept.
- PEND -> PEND on accept.
- PEND -> IDLE on commit without a new accept, or on flush.
- flags_busy = (state == PEND).
REQ-009 status_fwd SHALL equal pend_flags in PEND and status in IDLE, combinationally.
REQ-010 In flag_class 00, C/V SHALL be sourced from status_fwd so that a logic op following an add preserves the add's C/V.
REQ-011 On save_req, shadow SHALL load status_fwd at the rising edge (including a pending-but-uncommitted update).
REQ-012 On restore_req, status SHALL load shadow at the rising edge, any pending update SHALL be discarded, and the state SHALL go to IDLE.
- restore_req has priority over commit and over a new accept in the same cycle.
REQ-013 save_req and restore_req asserted together SHALL swap: shadow gets status_fwd and status gets the old shadow.
REQ-014 Flush SHALL take priority over accept and commit but not over restore_req.
REQ-015 Flags SHALL NOT be altered by any other input; ex_valid = 0 with s_bit = 1 is a no-op.

Reset
REQ-016 Reset SHALL act asynchronously and put the block in this state:
- status = 4'b0000, shadow = 4'b0000, pend_flags = 4'b0000
- state = IDLE, flags_busy = 0, status_fwd = 4'b0000
REQ-017 Reset asserted mid-PEND SHALL discard the pending update.
REQ-018 After rst_n deasserts, the first edge SHALL accept updates normally.

Verification
REQ-019 Sub that gives zero: flag_class 10, alu_result 0, alu_c 1, alu_v 0, s_bit 1 -> edge1 flags_busy = 1 and status_fwd = 0110; edge2 status = 0110, flags_busy = 0.
REQ-020 Add then logic op back-to-back:
- add: result 32'h8000_0000, c = 0, v = 1
- logic: result 1
- Final status = 0001, with V preserved from the add.
REQ-021 Capture add (result 5, c = 1), flush in the next cycle -> status stays 0000 and flags_busy drops.
REQ-022 With status = 1010, save_req, then a sub committing 0100, then restore_req -> status = 1010.
REQ-023 Accept and restore_req in the same cycle with shadow = 0011 -> status = 0011, state IDLE, new update dropped.
REQ-024 rst_n low asynchronously while PEND, mid-cycle -> all outputs 0 immediately, with no commit after release.
